// File: rtl/resolution_line_renderer.sv
// Fetches one 40-bit caption row from the resolution ROM per in-band line and shifts it out as a 1-bit overlay.
// pixel_on/de_out trail de/pixel_x by one clock; no backpressure, one caption pixel per active clock.
module resolution_line_renderer #(
  parameter int unsigned X_POS = 16,
  parameter int unsigned Y_POS = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_line_start,
  input  logic        i_de,
  input  logic [11:0] i_pixel_x,
  input  logic [11:0] i_pixel_y,
  output logic [3:0]  o_rom_addr,
  input  logic [39:0] i_rom_q,
  output logic        o_pixel_on,
  output logic        o_de_out
);

  localparam logic [11:0] XP = X_POS[11:0];
  localparam logic [11:0] YP = Y_POS[11:0];

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    ARMED,
    SHIFT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_rom_addr;
  logic [39:0] r_shreg;
  logic [5:0]  r_cnt;
  logic        r_pixel_on;
  logic        r_de_out;

  logic [12:0] w_y_ext;
  logic [12:0] w_y_top;
  logic [12:0] w_y_end;
  logic        w_in_band;
  logic [3:0]  w_row;

  // Band end is formed in 13 bits so a caption near the bottom of the 12-bit range cannot wrap.
  assign w_y_ext   = {1'b0, i_pixel_y};
  assign w_y_top   = {1'b0, YP};
  assign w_y_end   = w_y_top + 13'd16;
  assign w_in_band = (w_y_ext >= w_y_top) && (w_y_ext < w_y_end);
  assign w_row     = i_pixel_y[3:0] - YP[3:0];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_rom_addr <= 4'd0;
      r_shreg    <= 40'd0;
      r_cnt      <= 6'd0;
      r_pixel_on <= 1'b0;
      r_de_out   <= 1'b0;
    end else begin
      r_de_out   <= i_de;
      r_pixel_on <= 1'b0;
      if (i_line_start) begin
        // A new line always wins: abort whatever is in flight and re-evaluate the band.
        if (w_in_band) begin
          r_rom_addr <= w_row;
          r_state    <= FETCH;
        end else begin
          r_state    <= IDLE;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          FETCH: r_state <= CAPTURE;
          CAPTURE: begin
            r_shreg <= i_rom_q;
            r_cnt   <= 6'd0;
            r_state <= ARMED;
          end
          ARMED: begin
            if (i_de && (i_pixel_x == XP)) begin
              r_pixel_on <= r_shreg[39];
              r_shreg    <= {r_shreg[38:0], 1'b0};
              r_cnt      <= 6'd1;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (i_de) begin
              r_pixel_on <= r_shreg[39];
              r_shreg    <= {r_shreg[38:0], 1'b0};
              r_cnt      <= r_cnt + 6'd1;
              if (r_cnt == 6'd39) begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_pixel_on = r_pixel_on;
  assign o_de_out   = r_de_out;

endmodule
